// File: rtl/serial_slt_mod_if.sv
// Operand/result bundle for the bit-serial set-less-than unit.
// The master drives the request and operands; the slave returns status and results.
interface serial_slt_mod_if #(
    parameter int size = 8
);
    logic            start;
    logic [size-1:0] R3;
    logic [size-1:0] R2;
    logic            busy;
    logic            done;
    logic [size-1:0] R1;
    logic            c_out;
    logic [size-1:0] diff;

    modport master (
        output start, R3, R2,
        input  busy, done, R1, c_out, diff
    );

    modport slave (
        input  start, R3, R2,
        output busy, done, R1, c_out, diff
    );
endinterface

// File: rtl/serial_slt_mod.sv
// Bit-serial set-less-than: one full-adder slice computes R3 + ~R2 + 1, LSB first.
// The flag is the inverted MSB of the difference, with no overflow correction.
module serial_slt_mod #(
    parameter int size = 8
) (
    input logic             clk,
    input logic             rst,
    serial_slt_mod_if.slave bus
);
    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] b_q, b_d;
    logic [size-1:0] d_q, d_d;
    logic [size-1:0] diff_q, diff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            flag_q, flag_d;
    logic            sum_w;
    logic            cy_w;
    logic [size-1:0] d_shift_w;

    // One full-adder step on the current LSBs and the running carry.
    assign sum_w     = a_q[0] ^ b_q[0] ^ carry_q;
    assign cy_w      = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign d_shift_w = {sum_w, d_q[size-1:1]};

    // Next-state and datapath update; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.R3;
                    b_d     = ~bus.R2;
                    d_d     = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = {1'b0, a_q[size-1:1]};
                b_d     = {1'b0, b_q[size-1:1]};
                d_d     = d_shift_w;
                carry_d = cy_w;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = d_shift_w;
                    cout_d  = cy_w;
                    flag_d  = ~sum_w;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift registers, counter and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.R1    = {{(size-1){1'b0}}, flag_q};
    assign bus.c_out = cout_q;
    assign bus.diff  = diff_q;
endmodule

// File: tb/tb_serial_slt_mod.sv
// Bench for serial_slt_mod: fixed vectors, random operands against an
// arithmetic model, busy/reset corner cases and a size=4 back-to-back run.
module tb_serial_slt_mod;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_slt_mod_if #(.size(8)) b8 ();
    serial_slt_mod_if #(.size(4)) b4 ();

    serial_slt_mod #(.size(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    serial_slt_mod #(.size(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] r3;
        logic [7:0] r2;
        logic [7:0] d;
        logic [7:0] r1;
        logic       co;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Reference: plain modular subtraction and unsigned compare.
    function automatic void model(input int w, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] d,
                                  output logic [31:0] r1,
                                  output logic [31:0] co);
        longint unsigned m, aa, bb, dd;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bb = {32'd0, b} & m;
        dd = (aa - bb) & m;
        d  = dd[31:0];
        co = (aa >= bb) ? 32'd1 : 32'd0;
        r1 = dd[w-1] ? 32'd0 : 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; return in the done cycle (or at the bound).
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        b8.start = 1'b1;
        b8.R3    = a;
        b8.R2    = b;
        tick();
        b8.start = 1'b0;
        b8.R3    = 8'($urandom);
        b8.R2    = 8'($urandom);
        lat      = 0;
        while (!b8.done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          falls;
        logic        pb;
        logic [31:0] ed, er, ec;
        int          cyc, n, c1, c2;
        logic [3:0]  d1, d2;
        logic        r1a, r1b, co1, co2;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 8'h01, 1'b1};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 8'h00, 1'b0};
        tbl[2] = '{8'h7F, 8'h7F, 8'h00, 8'h01, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 8'h7F, 8'h01, 1'b1};
        tbl[4] = '{8'h01, 8'h80, 8'h81, 8'h00, 1'b0};
        tbl[5] = '{8'h00, 8'hFF, 8'h01, 8'h01, 1'b0};
        tbl[6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1};

        rst      = 1'b1;
        b8.start = 1'b0;
        b8.R3    = '0;
        b8.R2    = '0;
        b4.start = 1'b0;
        b4.R3    = '0;
        b4.R2    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(b8.busy), 32'd0);
        check("rst_done", 32'(b8.done), 32'd0);
        check("rst_r1", 32'(b8.R1), 32'd0);
        check("rst_cout", 32'(b8.c_out), 32'd0);
        check("rst_diff", 32'(b8.diff), 32'd0);
        check("rst4_busy", 32'(b4.busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run8(tbl[i].r3, tbl[i].r2, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_diff", i), 32'(b8.diff), 32'(tbl[i].d));
            check($sformatf("vec%0d_r1", i), 32'(b8.R1), 32'(tbl[i].r1));
            check($sformatf("vec%0d_cout", i), 32'(b8.c_out), 32'(tbl[i].co));
            check($sformatf("vec%0d_busy", i), 32'(b8.busy), 32'd1);
            tick();
            check($sformatf("vec%0d_pulse", i), 32'(b8.done), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            run8(a, b, lat);
            model(8, 32'(a), 32'(b), ed, er, ec);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("rnd%0d_diff", i), 32'(b8.diff), ed);
            check($sformatf("rnd%0d_r1", i), 32'(b8.R1), er);
            check($sformatf("rnd%0d_cout", i), 32'(b8.c_out), ec);
            tick();
        end

        b8.start = 1'b1;
        b8.R3    = 8'h10;
        b8.R2    = 8'h01;
        tick();
        b8.start = 1'b0;
        b8.R3    = 8'h00;
        b8.R2    = 8'hFF;
        falls    = 0;
        for (int c = 1; c <= 20; c++) begin
            b8.start = (c == 4) || b8.done;
            pb = b8.busy;
            tick();
            if (pb && !b8.busy) falls++;
        end
        b8.start = 1'b0;
        check("busy_falls", 32'(falls), 32'd1);
        check("busy_diff", 32'(b8.diff), 32'h0F);
        check("busy_r1", 32'(b8.R1), 32'h01);
        check("busy_cout", 32'(b8.c_out), 32'd1);
        check("busy_idle", 32'(b8.busy), 32'd0);

        b8.start = 1'b1;
        b8.R3    = 8'h55;
        b8.R2    = 8'h12;
        tick();
        b8.start = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_busy", 32'(b8.busy), 32'd0);
        check("mid_done", 32'(b8.done), 32'd0);
        check("mid_r1", 32'(b8.R1), 32'd0);
        check("mid_cout", 32'(b8.c_out), 32'd0);
        check("mid_diff", 32'(b8.diff), 32'd0);
        #1 rst = 1'b0;
        tick();
        run8(8'h22, 8'h11, lat);
        check("post_lat", 32'(lat), 32'd8);
        check("post_diff", 32'(b8.diff), 32'h11);
        check("post_r1", 32'(b8.R1), 32'h01);
        check("post_cout", 32'(b8.c_out), 32'd1);
        tick();

        b4.start = 1'b1;
        b4.R3    = 4'h3;
        b4.R2    = 4'h9;
        tick();
        b4.R3 = 4'h9;
        b4.R2 = 4'h3;
        cyc   = 0;
        n     = 0;
        c1    = 0;
        c2    = 0;
        d1    = '0;
        d2    = '0;
        r1a   = 1'b0;
        r1b   = 1'b0;
        co1   = 1'b0;
        co2   = 1'b0;
        while (n < 2 && cyc < 30) begin
            tick();
            cyc++;
            if (b4.done) begin
                if (n == 0) begin
                    c1  = cyc;
                    d1  = b4.diff;
                    r1a = b4.R1[0];
                    co1 = b4.c_out;
                end else begin
                    c2  = cyc;
                    d2  = b4.diff;
                    r1b = b4.R1[0];
                    co2 = b4.c_out;
                end
                n++;
            end
        end
        b4.start = 1'b0;
        check("b2b_count", 32'(n), 32'd2);
        check("b2b_first_lat", 32'(c1), 32'd4);
        check("b2b_period", 32'(c2 - c1), 32'd6);
        check("b2b_d1", 32'(d1), 32'hA);
        check("b2b_r1a", 32'(r1a), 32'd0);
        check("b2b_co1", 32'(co1), 32'd0);
        check("b2b_d2", 32'(d2), 32'h6);
        check("b2b_r1b", 32'(r1b), 32'd1);
        check("b2b_co2", 32'(co2), 32'd1);
        check("b2b_upper", 32'(b4.R1[3:1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
